// File: rtl/alu_dispatch_if.sv
// Bundle of the decoder, ALU and writeback signals around alu_dispatch.
// The slave modport is the dispatch block; the master modport is its environment.
interface alu_dispatch_if #(
  parameter int NREGS = 16,
  parameter int DW    = 32
);
  localparam int RW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_ra;
  logic [RW-1:0] in_rb;
  logic          in_use_imm;
  logic [DW-1:0] in_imm;

  logic [3:0]    alu_ctrl;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic          alu_zero;
  logic          alu_eq;
  logic          alu_gt;
  logic          alu_lt;

  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_res;
  logic [3:0]    out_flags;
  logic [15:0]   retired;

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm,
    output in_ready,
    output alu_ctrl, alu_a, alu_b,
    input  alu_res, alu_zero, alu_eq, alu_gt, alu_lt,
    output out_valid, out_rd, out_res, out_flags, retired,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm,
    input  in_ready,
    input  alu_ctrl, alu_a, alu_b,
    output alu_res, alu_zero, alu_eq, alu_gt, alu_lt,
    input  out_valid, out_rd, out_res, out_flags, retired,
    output out_ready
  );
endinterface

// File: rtl/alu_dispatch.sv
// Two-stage issue/writeback pipeline around an external combinational ALU:
// register file with bypassed operand read, execute register, handshaked result register.
module alu_dispatch #(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_dispatch_if.slave  bus
);
  localparam int RW = $clog2(NREGS);

  logic [DW-1:0] r_rf [NREGS];

  logic          r_e_valid;
  logic [3:0]    r_e_op;
  logic [RW-1:0] r_e_rd;
  logic [DW-1:0] r_e_a;
  logic [DW-1:0] r_e_b;

  logic          r_out_valid;
  logic [RW-1:0] r_out_rd;
  logic [DW-1:0] r_out_res;
  logic [3:0]    r_out_flags;
  logic [15:0]   r_retired;

  logic          w_free;
  logic          w_e_adv;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_hs;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;

  assign w_free     = !r_out_valid || bus.out_ready;
  assign w_e_adv    = r_e_valid && w_free;
  assign w_in_ready = !r_e_valid || w_free;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_hs       = r_out_valid && bus.out_ready;

  // Operand fetch; the instruction retiring from E this edge is bypassed from alu_res
  always_comb begin
    w_opa = {DW{1'b0}};
    w_opb = {DW{1'b0}};
    if (bus.in_ra == {RW{1'b0}}) begin
      w_opa = {DW{1'b0}};
    end else if (w_e_adv && (r_e_rd == bus.in_ra)) begin
      w_opa = bus.alu_res;
    end else begin
      w_opa = r_rf[bus.in_ra];
    end
    if (bus.in_use_imm) begin
      w_opb = bus.in_imm;
    end else if (bus.in_rb == {RW{1'b0}}) begin
      w_opb = {DW{1'b0}};
    end else if (w_e_adv && (r_e_rd == bus.in_rb)) begin
      w_opb = bus.alu_res;
    end else begin
      w_opb = r_rf[bus.in_rb];
    end
  end

  // Register file writeback; entry 0 is never written so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= {DW{1'b0}};
      end
    end else if (w_e_adv && (r_e_rd != {RW{1'b0}})) begin
      r_rf[r_e_rd] <= bus.alu_res;
    end
  end

  // Execute register; operand fields keep their last values while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_valid <= 1'b0;
      r_e_op    <= 4'd0;
      r_e_rd    <= {RW{1'b0}};
      r_e_a     <= {DW{1'b0}};
      r_e_b     <= {DW{1'b0}};
    end else if (w_accept) begin
      r_e_valid <= 1'b1;
      r_e_op    <= bus.in_op;
      r_e_rd    <= bus.in_rd;
      r_e_a     <= w_opa;
      r_e_b     <= w_opb;
    end else if (w_e_adv) begin
      r_e_valid <= 1'b0;
    end
  end

  // Result register with valid/ready handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_rd    <= {RW{1'b0}};
      r_out_res   <= {DW{1'b0}};
      r_out_flags <= 4'd0;
    end else if (w_e_adv) begin
      r_out_valid <= 1'b1;
      r_out_rd    <= r_e_rd;
      r_out_res   <= bus.alu_res;
      r_out_flags <= {bus.alu_lt, bus.alu_gt, bus.alu_eq, bus.alu_zero};
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count of results handed downstream, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= 16'd0;
    end else if (w_hs) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.alu_ctrl  = r_e_op;
  assign bus.alu_a     = r_e_a;
  assign bus.alu_b     = r_e_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_rd    = r_out_rd;
  assign bus.out_res   = r_out_res;
  assign bus.out_flags = r_out_flags;
  assign bus.retired   = r_retired;
endmodule
